coil_phase_decoder: RTL and testbench
=====================================

Name: coil_phase_decoder

Overview:
- Receive-side counterpart of the stepper coil driver: monitors the 4 coil-drive lines (driven on-board or looped back from the motor connector) and decodes the half-step phase sequence.
- Reports signed step position, direction, step rate, stall and sequence errors.
- Used for closed-loop checking of the step generator and as position source for the control logic.

Parameters:
- FILTER_CYCLES, 16, consecutive identical synchronized samples required before a coil pattern is accepted (min 1).
- POS_W, 32, width of signed position counter.
- PERIOD_W, 24, width of step-period measurement counter.
- STALL_CYCLES, 5000000, cycles without an accepted step before STALL asserts (100 ms at 50 MHz).

Ports:
- CLK50MHZ input 1: system clock, all state on rising edge.
- RSTN input 1: asynchronous active-low reset.
- COIL input 4: coil lines {A,B,C,D}, MSB = A, asynchronous to CLK50MHZ.
- CLR_ERR input 1: synchronous, clears ERR when high.
- POSITION output POS_W: signed step count, two's complement.
- DIR output 1: direction of last accepted step (1 = forward).
- STEP_PULSE output 1: one-cycle strobe per accepted position change.
- ERR_PULSE output 1: one-cycle strobe per sequence error.
- ERR output 1: sticky error flag.
- LOCKED output 1: a valid phase reference has been captured.
- PERIOD output PERIOD_W: cycles between the last two accepted steps, saturating.
- STALL output 1: no step for STALL_CYCLES cycles.

Behaviour:
- Reset, async, RSTN low: POSITION=0, DIR=0, STEP_PULSE=0, ERR_PULSE=0, ERR=0, LOCKED=0, PERIOD=0, STALL=0; sync flops, filter counter and period counter cleared.
- Input path: 2-flop synchronizer on COIL. Filter tracks a candidate pattern and a run counter.
  - Synced value differs from candidate: candidate <= synced, run <= 1.
  - Otherwise run increments, saturating at FILTER_CYCLES.
  - Pattern is accepted on the cycle run reaches FILTER_CYCLES.
- Phase table, accepted pattern -> index: 0100=0, 0110=1, 0010=2, 1010=3, 1000=4, 1001=5, 0001=6, 0101=7.
  - 0000 = idle: no output change, reference index kept.
  - All other patterns (0011, 0111, 1011, 1100, 1101, 1110, 1111) = invalid.
- Decode, one registered stage after acceptance. Only a change of the accepted pattern is evaluated; re-acceptance of the same pattern does nothing. With LOCKED=1, delta = (new_index - ref_index) mod 8:
  - delta 1: POSITION += 1, DIR=1, STEP_PULSE.
  - delta 2: POSITION += 2, DIR=1, STEP_PULSE (full-step drive).
  - delta 7: POSITION -= 1, DIR=0, STEP_PULSE.
  - delta 6: POSITION -= 2, DIR=0, STEP_PULSE.
  - delta 3/4/5: skipped phase; POSITION unchanged, ERR_PULSE, ERR=1, ref_index <= new_index.
  - ref_index <= new_index in every case.
- With LOCKED=0, a valid pattern sets ref_index and LOCKED=1 with no count and no pulse.
- Invalid pattern: ERR_PULSE, ERR=1, LOCKED=0 (next valid pattern re-locks without counting).
- Latency: STEP_PULSE/ERR_PULSE assert exactly FILTER_CYCLES+3 rising edges after the first edge at which COIL holds the new stable value.
- POSITION wraps modulo 2^POS_W, no saturation.
- Period counter: increments every cycle, saturating at 2^PERIOD_W-1.
  - On STEP_PULSE: PERIOD <= counter+1 (saturated), counter <= 0.
  - Error events do not touch the period counter.
- STALL: asserts when the period counter reaches STALL_CYCLES (or saturation if smaller); clears on the cycle STEP_PULSE asserts.
- Error clearing: CLR_ERR clears ERR next edge. A simultaneous error event wins: ERR stays 1.
- Reset mid-sequence: all state cleared; first valid pattern afterwards only re-locks.

Test Plan:
- Reset, then drive 0100, 0110, 0010, 1010 each held 100 cycles (FILTER_CYCLES=16) -> LOCKED after first, POSITION=3, DIR=1, three STEP_PULSEs each 19 edges after the change, ERR=0.
- From lock at 0100, drive 0101, 0001, 1001 -> POSITION=-3, DIR=0; then 0110 -> 1010 -> POSITION=-1, DIR=1.
- Glitch: pattern 0110 for 10 cycles between stable 0100 periods -> no STEP_PULSE, POSITION unchanged; 0110 held 16 cycles -> accepted.
- 0100 then 1000 (delta 4) -> ERR_PULSE once, ERR=1, POSITION unchanged; then 1001 -> POSITION+1; CLR_ERR pulse -> ERR=0.
- Invalid 1111 -> ERR=1, LOCKED=0; then 0010 -> LOCKED=1, no count; then 0000 idle -> no change; then 1010 -> POSITION+1.
- Steps every 1000 cycles -> PERIOD=1000; hold pattern with STALL_CYCLES=5000 -> STALL=1 at 5000 cycles, clears on next step; RSTN low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/coil_phase_decoder.sv
// Decodes the 4-wire half-step coil drive back into a signed step position,
// direction, step period, stall and phase-sequence error status.
module coil_phase_decoder #(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned POS_W         = 32,
    parameter int unsigned PERIOD_W      = 24,
    parameter int unsigned STALL_CYCLES  = 5000000
) (
    input  logic                CLK50MHZ,
    input  logic                RSTN,
    input  logic [3:0]          COIL,
    input  logic                CLR_ERR,
    output logic [POS_W-1:0]    POSITION,
    output logic                DIR,
    output logic                STEP_PULSE,
    output logic                ERR_PULSE,
    output logic                ERR,
    output logic                LOCKED,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic                STALL
);

    localparam int unsigned RUN_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER_CYCLES);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_W-1:0] STALL_LIM =
        (64'(STALL_CYCLES) >= ((64'(1) << PERIOD_W) - 64'(1))) ? PERIOD_MAX
                                                               : PERIOD_W'(STALL_CYCLES);

    logic [3:0]          sync1;
    logic [3:0]          sync2;
    logic [3:0]          cand;
    logic [RUN_W-1:0]    run;
    logic [3:0]          acc_pat;
    logic                acc_new;
    logic [2:0]          ref_idx;
    logic [PERIOD_W-1:0] period_cnt;

    logic [2:0]          idx_c;
    logic                valid_c;
    logic                idle_c;
    logic [2:0]          delta_c;
    logic                step_c;
    logic                err_c;
    logic                fwd_c;
    logic                double_c;
    logic                invalid_c;
    logic [POS_W-1:0]    amount_c;
    logic [PERIOD_W-1:0] cnt_inc_c;

    // Two-flop synchronizer for the asynchronous coil lines
    always_ff @(posedge CLK50MHZ or negedge RSTN) begin
        if (!RSTN) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= COIL;
            sync2 <= sync1;
        end
    end

    // Glitch filter: a pattern must persist FILTER_CYCLES samples; only a change
    // of the accepted pattern raises acc_new
    always_ff @(posedge CLK50MHZ or negedge RSTN) begin
        if (!RSTN) begin
            cand    <= 4'b0000;
            run     <= '0;
            acc_pat <= 4'b0000;
            acc_new <= 1'b0;
        end else begin
            acc_new <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                run  <= RUN_W'(1);
                if ((RUN_MAX == RUN_W'(1)) && (sync2 != acc_pat)) begin
                    acc_pat <= sync2;
                    acc_new <= 1'b1;
                end
            end else if (run < RUN_MAX) begin
                run <= run + RUN_W'(1);
                if (((run + RUN_W'(1)) == RUN_MAX) && (cand != acc_pat)) begin
                    acc_pat <= cand;
                    acc_new <= 1'b1;
                end
            end
        end
    end

    // Half-step phase table
    always_comb begin
        idx_c   = 3'd0;
        valid_c = 1'b0;
        idle_c  = 1'b0;
        case (acc_pat)
            4'b0100: begin idx_c = 3'd0; valid_c = 1'b1; end
            4'b0110: begin idx_c = 3'd1; valid_c = 1'b1; end
            4'b0010: begin idx_c = 3'd2; valid_c = 1'b1; end
            4'b1010: begin idx_c = 3'd3; valid_c = 1'b1; end
            4'b1000: begin idx_c = 3'd4; valid_c = 1'b1; end
            4'b1001: begin idx_c = 3'd5; valid_c = 1'b1; end
            4'b0001: begin idx_c = 3'd6; valid_c = 1'b1; end
            4'b0101: begin idx_c = 3'd7; valid_c = 1'b1; end
            4'b0000: idle_c = 1'b1;
            default: ;
        endcase
    end

    // Step classification from the modulo-8 phase distance
    always_comb begin
        delta_c   = idx_c - ref_idx;
        step_c    = 1'b0;
        err_c     = 1'b0;
        fwd_c     = 1'b0;
        double_c  = 1'b0;
        invalid_c = 1'b0;
        if (acc_new && !idle_c) begin
            if (!valid_c) begin
                invalid_c = 1'b1;
                err_c     = 1'b1;
            end else if (LOCKED) begin
                case (delta_c)
                    3'd1: begin step_c = 1'b1; fwd_c = 1'b1; end
                    3'd2: begin step_c = 1'b1; fwd_c = 1'b1; double_c = 1'b1; end
                    3'd7: step_c = 1'b1;
                    3'd6: begin step_c = 1'b1; double_c = 1'b1; end
                    3'd3, 3'd4, 3'd5: err_c = 1'b1;
                    default: ;
                endcase
            end
        end
        amount_c = double_c ? POS_W'(2) : POS_W'(1);
    end

    // Decode stage: position, direction, lock and error flags
    always_ff @(posedge CLK50MHZ or negedge RSTN) begin
        if (!RSTN) begin
            POSITION   <= '0;
            DIR        <= 1'b0;
            STEP_PULSE <= 1'b0;
            ERR_PULSE  <= 1'b0;
            ERR        <= 1'b0;
            LOCKED     <= 1'b0;
            ref_idx    <= 3'd0;
        end else begin
            STEP_PULSE <= step_c;
            ERR_PULSE  <= err_c;
            if (step_c) begin
                POSITION <= fwd_c ? (POSITION + amount_c) : (POSITION - amount_c);
                DIR      <= fwd_c;
            end
            if (acc_new && valid_c) begin
                ref_idx <= idx_c;
            end
            if (invalid_c) begin
                LOCKED <= 1'b0;
            end else if (acc_new && valid_c) begin
                LOCKED <= 1'b1;
            end
            if (err_c) begin
                ERR <= 1'b1;
            end else if (CLR_ERR) begin
                ERR <= 1'b0;
            end
        end
    end

    assign cnt_inc_c = (period_cnt == PERIOD_MAX) ? PERIOD_MAX : (period_cnt + PERIOD_W'(1));

    // Step period measurement and stall detection
    always_ff @(posedge CLK50MHZ or negedge RSTN) begin
        if (!RSTN) begin
            period_cnt <= '0;
            PERIOD     <= '0;
            STALL      <= 1'b0;
        end else if (step_c) begin
            PERIOD     <= cnt_inc_c;
            period_cnt <= '0;
            STALL      <= 1'b0;
        end else begin
            period_cnt <= cnt_inc_c;
            if (cnt_inc_c >= STALL_LIM) begin
                STALL <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coil_phase_decoder.sv
// Directed bench for coil_phase_decoder: stepping, glitch filter, errors,
// period, stall and reset behaviour with hand-computed expectations.
module tb_coil_phase_decoder;

    localparam int unsigned FC    = 16;
    localparam int unsigned POS_W = 32;
    localparam int unsigned PER_W = 24;
    localparam int unsigned STALL = 5000;

    logic             clk;
    logic             rst_n;
    logic [3:0]       coil;
    logic             clr_err;
    logic [POS_W-1:0] position;
    logic             dir;
    logic             step_pulse;
    logic             err_pulse;
    logic             err;
    logic             locked;
    logic [PER_W-1:0] period;
    logic             stall;

    int errors = 0;
    int checks = 0;
    int steps;
    int errs;
    int step_edge;
    int err_edge;
    int total_steps;

    coil_phase_decoder #(
        .FILTER_CYCLES(FC),
        .POS_W(POS_W),
        .PERIOD_W(PER_W),
        .STALL_CYCLES(STALL)
    ) dut (
        .CLK50MHZ(clk),
        .RSTN(rst_n),
        .COIL(coil),
        .CLR_ERR(clr_err),
        .POSITION(position),
        .DIR(dir),
        .STEP_PULSE(step_pulse),
        .ERR_PULSE(err_pulse),
        .ERR(err),
        .LOCKED(locked),
        .PERIOD(period),
        .STALL(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a pattern for n edges, counting pulses and the edge of the first one
    task automatic apply(input logic [3:0] pat, input int n);
        coil      = pat;
        steps     = 0;
        errs      = 0;
        step_edge = 0;
        err_edge  = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (step_pulse) begin
                steps++;
                if (step_edge == 0) step_edge = i;
            end
            if (err_pulse) begin
                errs++;
                if (err_edge == 0) err_edge = i;
            end
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        coil    = 4'b0000;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (position !== 32'd0 || dir !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_pos_dir_lock: got pos=%0d dir=%b lock=%b, expected 0 0 0",
                     $signed(position), dir, locked);
        end
        checks++;
        if (step_pulse !== 1'b0 || err_pulse !== 1'b0 || err !== 1'b0 ||
            period !== 24'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got sp=%b ep=%b err=%b per=%0d stall=%b, expected all 0",
                     step_pulse, err_pulse, err, period, stall);
        end
    endtask

    task automatic test_forward();
        do_reset();
        apply(4'b0100, 100);
        checks++;
        if (locked !== 1'b1 || steps !== 0) begin
            errors++;
            $display("FAIL fwd_lock: got lock=%b steps=%0d, expected 1 0", locked, steps);
        end
        apply(4'b0110, 100);
        checks++;
        if (steps !== 1 || step_edge !== 19) begin
            errors++;
            $display("FAIL fwd_latency1: got steps=%0d edge=%0d, expected 1 19", steps, step_edge);
        end
        apply(4'b0010, 100);
        checks++;
        if (steps !== 1 || step_edge !== 19) begin
            errors++;
            $display("FAIL fwd_latency2: got steps=%0d edge=%0d, expected 1 19", steps, step_edge);
        end
        apply(4'b1010, 100);
        checks++;
        if (steps !== 1 || step_edge !== 19) begin
            errors++;
            $display("FAIL fwd_latency3: got steps=%0d edge=%0d, expected 1 19", steps, step_edge);
        end
        checks++;
        if ($signed(position) !== 3 || dir !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL fwd_final: got pos=%0d dir=%b err=%b, expected 3 1 0",
                     $signed(position), dir, err);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        apply(4'b0100, 100);
        apply(4'b0101, 100);
        apply(4'b0001, 100);
        apply(4'b1001, 100);
        checks++;
        if ($signed(position) !== -3 || dir !== 1'b0) begin
            errors++;
            $display("FAIL rev_pos: got pos=%0d dir=%b, expected -3 0", $signed(position), dir);
        end
        // 1001 -> 0110 is a four-phase jump, then 0110 -> 1010 is a full step
        apply(4'b0110, 100);
        checks++;
        if (errs !== 1 || steps !== 0 || $signed(position) !== -3) begin
            errors++;
            $display("FAIL rev_jump: got errs=%0d steps=%0d pos=%0d, expected 1 0 -3",
                     errs, steps, $signed(position));
        end
        apply(4'b1010, 100);
        checks++;
        if ($signed(position) !== -1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL rev_full_step: got pos=%0d dir=%b, expected -1 1", $signed(position), dir);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        apply(4'b0100, 100);
        apply(4'b0110, 10);
        total_steps = steps;
        apply(4'b0100, 60);
        total_steps += steps;
        apply(4'b0110, 15);
        total_steps += steps;
        apply(4'b0100, 60);
        total_steps += steps;
        checks++;
        if (total_steps !== 0 || position !== 32'd0) begin
            errors++;
            $display("FAIL glitch_reject: got steps=%0d pos=%0d, expected 0 0",
                     total_steps, $signed(position));
        end
        apply(4'b0110, 16);
        total_steps = steps;
        apply(4'b0000, 40);
        total_steps += steps;
        checks++;
        if (total_steps !== 1 || $signed(position) !== 1) begin
            errors++;
            $display("FAIL glitch_accept16: got steps=%0d pos=%0d, expected 1 1",
                     total_steps, $signed(position));
        end
    endtask

    task automatic test_skip_error();
        do_reset();
        apply(4'b0100, 100);
        apply(4'b1000, 100);
        checks++;
        if (errs !== 1 || err_edge !== 19 || err !== 1'b1 || steps !== 0 || position !== 32'd0) begin
            errors++;
            $display("FAIL skip_err: got errs=%0d edge=%0d err=%b steps=%0d pos=%0d, expected 1 19 1 0 0",
                     errs, err_edge, err, steps, $signed(position));
        end
        apply(4'b1001, 100);
        checks++;
        if ($signed(position) !== 1 || err !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL skip_resume: got pos=%0d err=%b lock=%b, expected 1 1 1",
                     $signed(position), err, locked);
        end
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got err=%b, expected 0", err);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        apply(4'b0100, 100);
        apply(4'b1111, 100);
        checks++;
        if (err !== 1'b1 || locked !== 1'b0 || errs !== 1) begin
            errors++;
            $display("FAIL invalid: got err=%b lock=%b errs=%0d, expected 1 0 1", err, locked, errs);
        end
        apply(4'b0010, 100);
        checks++;
        if (locked !== 1'b1 || steps !== 0 || position !== 32'd0) begin
            errors++;
            $display("FAIL relock: got lock=%b steps=%0d pos=%0d, expected 1 0 0",
                     locked, steps, $signed(position));
        end
        apply(4'b0000, 100);
        checks++;
        if (locked !== 1'b1 || steps !== 0 || errs !== 0 || position !== 32'd0) begin
            errors++;
            $display("FAIL idle: got lock=%b steps=%0d errs=%0d pos=%0d, expected 1 0 0 0",
                     locked, steps, errs, $signed(position));
        end
        apply(4'b1010, 100);
        checks++;
        if ($signed(position) !== 1 || steps !== 1) begin
            errors++;
            $display("FAIL after_idle: got pos=%0d steps=%0d, expected 1 1", $signed(position), steps);
        end
    endtask

    task automatic test_period_stall_reset();
        do_reset();
        apply(4'b0100, 100);
        apply(4'b0110, 1000);
        apply(4'b0010, 1000);
        apply(4'b1010, 100);
        checks++;
        if (period !== 24'd1000 || stall !== 1'b0) begin
            errors++;
            $display("FAIL period: got period=%0d stall=%b, expected 1000 0", period, stall);
        end
        // last step was at edge 19 of the 100-edge hold: 81 cycles already elapsed
        repeat (4918) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: got stall=%b at 4999 cycles, expected 0", stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_assert: got stall=%b at 5000 cycles, expected 1", stall);
        end
        apply(4'b1000, 40);
        checks++;
        if (stall !== 1'b0 || steps !== 1 || $signed(position) !== 4) begin
            errors++;
            $display("FAIL stall_clear: got stall=%b steps=%0d pos=%0d, expected 0 1 4",
                     stall, steps, $signed(position));
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (position !== 32'd0 || dir !== 1'b0 || locked !== 1'b0 || period !== 24'd0 ||
            stall !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got pos=%0d dir=%b lock=%b per=%0d stall=%b err=%b, expected all 0",
                     $signed(position), dir, locked, period, stall, err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'b1000, 100);
        checks++;
        if (locked !== 1'b1 || steps !== 0 || position !== 32'd0) begin
            errors++;
            $display("FAIL reset_relock: got lock=%b steps=%0d pos=%0d, expected 1 0 0",
                     locked, steps, $signed(position));
        end
        apply(4'b1001, 100);
        checks++;
        if ($signed(position) !== 1 || step_edge !== 19) begin
            errors++;
            $display("FAIL reset_step: got pos=%0d edge=%0d, expected 1 19", $signed(position), step_edge);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        coil    = 4'b0000;
        clr_err = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_skip_error();
        test_invalid();
        test_period_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
